// File: rtl/ahb2apb_bridge_param.sv
// ---------------------------------------------------------------------------
// ahb2apb_bridge_param
//
// Purpose:
//   Single-outstanding AHB-to-APB bridge. An AHB NONSEQ/SEQ transfer that
//   falls inside one of NUM_SLAVES equal-size regions starting at BASE_ADDR
//   becomes one APB SETUP/ACCESS cycle pair on the matching select line.
//   A transfer outside the decoded window, a slave error, or an APB access
//   that stalls longer than TIMEOUT cycles produces the two-cycle AHB ERROR
//   response. Every output comes straight from a register.
//
// Ports:
//   Hclk        clock, everything on the rising edge
//   Hreset      synchronous active-high reset
//   Hwrite      AHB direction (1 = write)
//   Hreadyin    AHB bus ready
//   Htrans      AHB transfer type (bit 1 set = NONSEQ/SEQ)
//   Haddr       AHB address
//   Hwdata      AHB write data (data phase)
//   Prdata      muxed APB read data
//   Pready      APB slave ready
//   Pslverr     APB slave error
//   Hreadyout   AHB ready back to the master
//   Hresp       AHB response (00 OKAY, 01 ERROR)
//   Hrdata      AHB read data
//   Pselx       one-hot APB slave select
//   Penable     APB enable
//   Pwrite      APB direction
//   Paddr       APB address
//   Pwdata      APB write data
// ---------------------------------------------------------------------------
module ahb2apb_bridge_param #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    NUM_SLAVES  = 3,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
   parameter int                    REGION_BITS = 26,
   parameter int                    TIMEOUT     = 16
) (
   input  logic                  Hclk,
   input  logic                  Hreset,
   input  logic                  Hwrite,
   input  logic                  Hreadyin,
   input  logic [1:0]            Htrans,
   input  logic [ADDR_WIDTH-1:0] Haddr,
   input  logic [DATA_WIDTH-1:0] Hwdata,
   input  logic [DATA_WIDTH-1:0] Prdata,
   input  logic                  Pready,
   input  logic                  Pslverr,
   output logic                  Hreadyout,
   output logic [1:0]            Hresp,
   output logic [DATA_WIDTH-1:0] Hrdata,
   output logic [NUM_SLAVES-1:0] Pselx,
   output logic                  Penable,
   output logic                  Pwrite,
   output logic [ADDR_WIDTH-1:0] Paddr,
   output logic [DATA_WIDTH-1:0] Pwdata
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WWAIT  = 3'd1;
   localparam logic [2:0] ST_SETUP  = 3'd2;
   localparam logic [2:0] ST_ACCESS = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;
   localparam logic [2:0] ST_ERR1   = 3'd5;
   localparam logic [2:0] ST_ERR2   = 3'd6;

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;

   // Wide enough to hold TIMEOUT itself; one bit when the timeout is off.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   logic [2:0]            state_q,     state_d;
   logic [NUM_SLAVES-1:0] sel_q,       sel_d;
   logic [NUM_SLAVES-1:0] pselx_q,     pselx_d;
   logic                  penable_q,   penable_d;
   logic                  pwrite_q,    pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
   logic [DATA_WIDTH-1:0] hrdata_q,    hrdata_d;
   logic                  hreadyout_q, hreadyout_d;
   logic [1:0]            hresp_q,     hresp_d;
   logic [CNT_W-1:0]      cnt_q,       cnt_d;

   // ---------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------
   logic                  xfer_valid;
   logic [ADDR_WIDTH-1:0] addr_offset;
   logic [ADDR_WIDTH-1:0] slave_idx;
   logic                  addr_hit;
   logic [NUM_SLAVES-1:0] sel_dec;
   logic                  unused_htrans;

   // Only bit 1 of Htrans distinguishes NONSEQ/SEQ from IDLE/BUSY.
   assign unused_htrans = Htrans[0];
   assign xfer_valid    = Hreadyin & Htrans[1];
   assign addr_offset   = Haddr - BASE_ADDR;
   assign slave_idx     = addr_offset >> REGION_BITS;
   // The >= test rejects addresses below the window whose subtraction wrapped.
   assign addr_hit      = (Haddr >= BASE_ADDR) &&
                          (slave_idx < ADDR_WIDTH'(NUM_SLAVES));

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel_dec
         assign sel_dec[gi] = (slave_idx == ADDR_WIDTH'(gi));
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Stall counter for the ACCESS timeout
   // ---------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_inc;
   logic             timeout_hit;

   assign cnt_inc     = cnt_q + 1'b1;
   assign timeout_hit = (TIMEOUT > 0) && (cnt_inc == CNT_W'(TIMEOUT));

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   logic accept;

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      pselx_d     = pselx_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      hrdata_d    = hrdata_q;
      hreadyout_d = hreadyout_q;
      hresp_d     = hresp_q;
      cnt_d       = cnt_q;
      accept      = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR2: begin
            accept = 1'b1;
         end
         ST_WWAIT: begin
            // Hwdata is valid now (AHB data phase); select goes out with it.
            pwdata_d = Hwdata;
            pselx_d  = sel_q;
            state_d  = ST_SETUP;
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (Pready) begin
               pselx_d   = '0;
               penable_d = 1'b0;
               cnt_d     = '0;
               if (Pslverr) begin
                  state_d     = ST_ERR1;
                  hreadyout_d = 1'b0;
                  hresp_d     = RESP_ERROR;
               end else begin
                  state_d     = ST_DONE;
                  hreadyout_d = 1'b1;
                  hresp_d     = RESP_OKAY;
                  if (!pwrite_q) begin
                     hrdata_d = Prdata;
                  end
               end
            end else if (timeout_hit) begin
               // Abandon the stalled slave and report an error to the master.
               pselx_d     = '0;
               penable_d   = 1'b0;
               cnt_d       = '0;
               state_d     = ST_ERR1;
               hreadyout_d = 1'b0;
               hresp_d     = RESP_ERROR;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_ERR1: begin
            state_d     = ST_ERR2;
            hreadyout_d = 1'b1;
            hresp_d     = RESP_ERROR;
         end
         default: begin
            state_d     = ST_IDLE;
            hreadyout_d = 1'b1;
            hresp_d     = RESP_OKAY;
         end
      endcase

      // IDLE, DONE and ERR2 all act as an AHB address phase, which is what
      // lets a new transfer follow a completion with no idle cycle between.
      if (accept) begin
         if (xfer_valid) begin
            if (addr_hit) begin
               paddr_d     = Haddr;
               pwrite_d    = Hwrite;
               sel_d       = sel_dec;
               hreadyout_d = 1'b0;
               hresp_d     = RESP_OKAY;
               if (Hwrite) begin
                  state_d = ST_WWAIT;
               end else begin
                  pselx_d = sel_dec;
                  state_d = ST_SETUP;
               end
            end else begin
               state_d     = ST_ERR1;
               hreadyout_d = 1'b0;
               hresp_d     = RESP_ERROR;
            end
         end else begin
            state_d     = ST_IDLE;
            hreadyout_d = 1'b1;
            hresp_d     = RESP_OKAY;
         end
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         state_q     <= ST_IDLE;
         sel_q       <= '0;
         pselx_q     <= '0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         hrdata_q    <= '0;
         hreadyout_q <= 1'b1;
         hresp_q     <= RESP_OKAY;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         pselx_q     <= pselx_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         hrdata_q    <= hrdata_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
         cnt_q       <= cnt_d;
      end
   end

   assign Hreadyout = hreadyout_q;
   assign Hresp     = hresp_q;
   assign Hrdata    = hrdata_q;
   assign Pselx     = pselx_q;
   assign Penable   = penable_q;
   assign Pwrite    = pwrite_q;
   assign Paddr     = paddr_q;
   assign Pwdata    = pwdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge_param.sv
// ---------------------------------------------------------------------------
// tb_ahb2apb_bridge_param
//
// Directed bench for ahb2apb_bridge_param with default parameters (3 slaves
// of 64 MB from 0x8000_0000, TIMEOUT 16). A table of single transfers is
// replayed with a small APB slave model; back-to-back reads and a reset in
// the middle of ACCESS are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_ahb2apb_bridge_param;

   logic        Hclk;
   logic        Hreset;
   logic        Hwrite;
   logic        Hreadyin;
   logic [1:0]  Htrans;
   logic [31:0] Haddr;
   logic [31:0] Hwdata;
   logic [31:0] Prdata;
   logic        Pready;
   logic        Pslverr;
   logic        Hreadyout;
   logic [1:0]  Hresp;
   logic [31:0] Hrdata;
   logic [2:0]  Pselx;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;

   int checks   = 0;
   int failures = 0;

   ahb2apb_bridge_param dut (
      .Hclk      (Hclk),
      .Hreset    (Hreset),
      .Hwrite    (Hwrite),
      .Hreadyin  (Hreadyin),
      .Htrans    (Htrans),
      .Haddr     (Haddr),
      .Hwdata    (Hwdata),
      .Prdata    (Prdata),
      .Pready    (Pready),
      .Pslverr   (Pslverr),
      .Hreadyout (Hreadyout),
      .Hresp     (Hresp),
      .Hrdata    (Hrdata),
      .Pselx     (Pselx),
      .Penable   (Penable),
      .Pwrite    (Pwrite),
      .Paddr     (Paddr),
      .Pwdata    (Pwdata)
   );

   initial Hclk = 1'b0;
   always #5 Hclk = ~Hclk;

   typedef struct {
      logic [31:0] haddr;
      logic        hwrite;
      logic [31:0] hwdata;
      logic [31:0] prdata;
      int          wait_cycles;
      logic        slverr;
      logic [2:0]  exp_psel;
      int          exp_psel_cyc;
      int          exp_pen_cyc;
      int          exp_lat;
      logic [1:0]  exp_hresp;
      logic [31:0] exp_hrdata;
   } vec_t;

   localparam int NVEC = 10;
   vec_t vecs [NVEC];

   task automatic tick();
      @(posedge Hclk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_reset(input string pfx);
      check({pfx, "_pselx"},   Pselx,     0);
      check({pfx, "_penable"}, Penable,   0);
      check({pfx, "_pwrite"},  Pwrite,    0);
      check({pfx, "_paddr"},   Paddr,     0);
      check({pfx, "_pwdata"},  Pwdata,    0);
      check({pfx, "_hrdata"},  Hrdata,    0);
      check({pfx, "_hready"},  Hreadyout, 1);
      check({pfx, "_hresp"},   Hresp,     0);
   endtask

   // Runs one transfer from IDLE; the slave model asserts Pready after
   // wait_cycles ACCESS cycles. Latency counts from the address-phase cycle.
   task automatic run_txn(input vec_t v, input int idx);
      int         cyc;
      int         acc;
      int         psel_cyc;
      int         pen_cyc;
      logic [2:0] psel_or;
      logic       stable;
      logic       done;
      logic [1:0] hresp_prev;

      check($sformatf("v%0d_idle_ready", idx), Hreadyout, 1);
      check($sformatf("v%0d_idle_hresp", idx), Hresp, 0);
      Haddr    = v.haddr;
      Hwrite   = v.hwrite;
      Htrans   = 2'b10;
      Hreadyin = 1'b1;
      Prdata   = v.prdata;
      Pready   = 1'b0;
      Pslverr  = 1'b0;
      hresp_prev = Hresp;
      tick();
      Htrans = 2'b00;
      Hwdata = v.hwdata;

      cyc = 1; acc = 0; psel_cyc = 0; pen_cyc = 0;
      psel_or = '0; stable = 1'b1; done = 1'b0;
      while (!done && cyc <= 40) begin
         if (Pselx != 3'b000) begin
            psel_cyc++;
            psel_or |= Pselx;
            if (Paddr !== v.haddr || Pwrite !== v.hwrite ||
                (v.hwrite && Pwdata !== v.hwdata))
               stable = 1'b0;
         end
         if (Penable) begin
            pen_cyc++;
            Pready  = (acc >= v.wait_cycles);
            Pslverr = (acc >= v.wait_cycles) ? v.slverr : 1'b0;
            acc++;
         end else begin
            Pready  = 1'b0;
            Pslverr = 1'b0;
         end
         if (Hreadyout) begin
            done = 1'b1;
         end else begin
            hresp_prev = Hresp;
            tick();
            cyc++;
         end
      end

      if (!done) begin
         check($sformatf("v%0d_ready_timeout", idx), 0, 1);
      end else begin
         $display("txn %0d addr=%08h wr=%0d lat=%0d hresp=%0d hrdata=%08h",
                  idx, v.haddr, v.hwrite, cyc, Hresp, Hrdata);
         check($sformatf("v%0d_latency", idx),    cyc,        v.exp_lat);
         check($sformatf("v%0d_hresp", idx),      Hresp,      v.exp_hresp);
         check($sformatf("v%0d_hresp_prev", idx), hresp_prev, v.exp_hresp);
         check($sformatf("v%0d_hrdata", idx),     Hrdata,     v.exp_hrdata);
         check($sformatf("v%0d_psel", idx),       psel_or,    v.exp_psel);
         check($sformatf("v%0d_psel_cyc", idx),   psel_cyc,   v.exp_psel_cyc);
         check($sformatf("v%0d_pen_cyc", idx),    pen_cyc,    v.exp_pen_cyc);
         check($sformatf("v%0d_apb_stable", idx), stable,     1);
      end
      Pready  = 1'b0;
      Pslverr = 1'b0;
      tick();
   endtask

   initial begin
      //            haddr         wr    hwdata        prdata        wait slverr psel    psc pec lat resp   hrdata
      vecs[0] = '{32'h8400_0010, 1'b0, 32'h0,        32'hDEAD_BEEF, 0,  1'b0, 3'b010,  2,  1,  3, 2'b00, 32'hDEAD_BEEF};
      vecs[1] = '{32'h8800_0004, 1'b1, 32'h1234_5678, 32'hBAD0_BAD0, 0,  1'b0, 3'b100,  2,  1,  4, 2'b00, 32'hDEAD_BEEF};
      vecs[2] = '{32'h9000_0000, 1'b0, 32'h0,        32'h5555_5555, 0,  1'b0, 3'b000,  0,  0,  2, 2'b01, 32'hDEAD_BEEF};
      vecs[3] = '{32'h8000_0000, 1'b0, 32'h0,        32'h0000_1111, 2,  1'b0, 3'b001,  4,  3,  5, 2'b00, 32'h0000_1111};
      vecs[4] = '{32'h8000_0100, 1'b0, 32'h0,        32'h2222_2222, 3,  1'b1, 3'b001,  5,  4,  7, 2'b01, 32'h0000_1111};
      vecs[5] = '{32'h8BFF_FFFC, 1'b1, 32'hCAFE_0001, 32'h3333_3333, 1,  1'b0, 3'b100,  3,  2,  5, 2'b00, 32'h0000_1111};
      vecs[6] = '{32'h7FFF_FFFC, 1'b0, 32'h0,        32'h6666_6666, 0,  1'b0, 3'b000,  0,  0,  2, 2'b01, 32'h0000_1111};
      vecs[7] = '{32'h8C00_0000, 1'b1, 32'h7777_7777, 32'h7777_7777, 0,  1'b0, 3'b000,  0,  0,  2, 2'b01, 32'h0000_1111};
      vecs[8] = '{32'h8400_0000, 1'b0, 32'h0,        32'h4444_4444, 100, 1'b0, 3'b010, 17, 16, 19, 2'b01, 32'h0000_1111};
      vecs[9] = '{32'h8800_0010, 1'b1, 32'h0F0F_0F0F, 32'h8888_8888, 0,  1'b1, 3'b100,  2,  1,  5, 2'b01, 32'h0000_1111};

      Hreset   = 1'b1;
      Hwrite   = 1'b0;
      Hreadyin = 1'b1;
      Htrans   = 2'b00;
      Haddr    = '0;
      Hwdata   = '0;
      Prdata   = '0;
      Pready   = 1'b0;
      Pslverr  = 1'b0;
      tick();
      tick();
      check_reset("reset");
      Hreset = 1'b0;
      tick();

      for (int i = 0; i < NVEC; i++) run_txn(vecs[i], i);

      // Back-to-back reads: second address phase in the DONE cycle.
      Pready  = 1'b1;
      Prdata  = 32'hAAAA_0001;
      Haddr   = 32'h8000_0020;
      Hwrite  = 1'b0;
      Htrans  = 2'b10;
      tick();                                  // SETUP
      Htrans = 2'b00;
      check("b2b_setup1_psel", Pselx, 3'b001);
      tick();                                  // ACCESS
      check("b2b_access1_pen", Penable, 1);
      tick();                                  // DONE
      check("b2b_done1_ready", Hreadyout, 1);
      check("b2b_done1_hrdata", Hrdata, 32'hAAAA_0001);
      $display("txn b2b1 addr=80000020 hrdata=%08h", Hrdata);
      Haddr  = 32'h8400_0030;
      Htrans = 2'b10;
      Prdata = 32'hBBBB_0002;
      tick();                                  // SETUP of second read
      Htrans = 2'b00;
      check("b2b_setup2_psel", Pselx, 3'b010);
      check("b2b_setup2_pen", Penable, 0);
      check("b2b_setup2_paddr", Paddr, 32'h8400_0030);
      check("b2b_setup2_ready", Hreadyout, 0);
      tick();                                  // ACCESS
      tick();                                  // DONE
      check("b2b_done2_ready", Hreadyout, 1);
      check("b2b_done2_hrdata", Hrdata, 32'hBBBB_0002);
      $display("txn b2b2 addr=84000030 hrdata=%08h", Hrdata);
      Pready = 1'b0;
      tick();

      // Reset while a write is stalled in ACCESS.
      Haddr  = 32'h8800_0008;
      Hwrite = 1'b1;
      Htrans = 2'b10;
      tick();                                  // WWAIT
      Htrans = 2'b00;
      Hwdata = 32'h5555_AAAA;
      tick();                                  // SETUP
      check("midrst_pre_psel", Pselx, 3'b100);
      tick();                                  // ACCESS
      check("midrst_pre_pen", Penable, 1);
      check("midrst_pre_pwdata", Pwdata, 32'h5555_AAAA);
      Hreset = 1'b1;
      tick();
      Hreset = 1'b0;
      check_reset("midrst");
      $display("txn midrst addr=88000008 pselx=%0b hready=%0d", Pselx, Hreadyout);
      tick();
      tick();
      check("midrst_after_ready", Hreadyout, 1);
      check("midrst_after_hresp", Hresp, 0);
      check("midrst_after_psel", Pselx, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
